frame_tx_scheduler: RTL
=======================

// Module: frame_tx_scheduler
// PURPOSE
//  Chooses which 128-bit frame goes to the serial frame serialiser next.
//  There are three sources: periodic status/sync frames, trace frames from the frame buffer, and host reply frames.
//  Sits between the frame buffer / reply generator and the serialiser, and owns the sync-interval timer.
//  Fixed priority, with a starvation guard so replies are not blocked indefinitely by trace traffic.
// PARAMETERS
//  SYNC_W        23  width of sync interval timer and SyncIntervalSet
//  MAX_TRACE_RUN 8   consecutive trace grants allowed while a reply is pending (>=1)
// PORTS
//  clk             in  1     clock
//  rst             in  1     reset, asynchronous, active-high
//  Enable          in  1     1 = grants allowed; 0 = no new grants
//  SyncIntervalSet in  SYNC_W cycles between status frames, reloaded at each status grant
//  StatusFrame     in  128   externally assembled status/sync frame, sampled at grant
//  TraceFrame      in  128   head of trace frame buffer
//  TraceReady      in  1     trace frame available
//  TraceNext       out 1     1-cycle pop pulse to frame buffer
//  ReplyFrame      in  128   host reply frame
//  ReplyValid      in  1     reply frame available (level, held until ReplyAck)
//  ReplyAck        out 1     1-cycle consume pulse to reply source
//  OutFrame        out 128   frame offered to serialiser
//  OutValid        out 1     OutFrame valid; held until OutTaken
//  OutTaken        in  1     serialiser has latched OutFrame
//  Grant           out 2     source of current OutFrame: 0 none, 1 status, 2 trace, 3 reply
//  SyncDue         out 1     sync timer == 0
//  SyncsSent       out 16    status frames granted (wraps)
// BEHAVIOUR
//  Reset values: OutValid=0, OutFrame=0, Grant=0, TraceNext=0, ReplyAck=0, SyncsSent=0.
//  Reset values (internal): timer=0, so SyncDue=1 and the first grant is a status frame; run counter=0; state=IDLE.
//  States: IDLE, OFFER.
//  IDLE, Enable=1: arbitrate in this cycle, using these priorities:
//   1. SyncDue -> status.
//   2. ReplyValid && run==MAX_TRACE_RUN -> reply.
//   3. TraceReady -> trace.
//   4. ReplyValid -> reply.
//   5. Otherwise stay in IDLE.
//  On a grant, at the same clock edge:
//   - capture the frame into OutFrame;
//   - set Grant;
//   - set OutValid=1;
//   - go to OFFER.
//   Latency: request seen in cycle N -> OutValid high in cycle N+1.
//  Pulses on a grant, at that same edge:
//   - TraceNext=1 for exactly one cycle on a trace grant;
//   - ReplyAck=1 for exactly one cycle on a reply grant;
//   - never both.
//  OFFER:
//   - OutValid and OutFrame stay stable until OutTaken=1.
//   - On OutTaken: OutValid=0, Grant=0, return to IDLE. The next grant is no earlier than the following cycle.
//   - OutTaken while OutValid=0 is ignored.
//  Sync timer:
//   - Decrements by 1 every cycle while it is nonzero, in every state.
//   - Saturates at 0.
//   - On a status grant it loads SyncIntervalSet; that load overrides the decrement in the same cycle.
//   - SyncIntervalSet=0 makes the timer stay 0, so a status frame is sent on every grant.
//  Run counter:
//   - Trace grant with ReplyValid=1: +1, saturating at MAX_TRACE_RUN.
//   - Trace grant with ReplyValid=0: cleared to 0.
//   - Reply grant: cleared to 0.
//   - Status grant: unchanged.
//  SyncsSent: +1 on each status grant, modulo 2^16.
//  Enable=0: no new grants. An OFFER in progress completes normally. The timer keeps running.
//  Reset mid-OFFER: the offered frame is dropped. Its source was already popped, so the frame is lost; this is accepted.
// TESTING
//  Release reset, Enable=1, TraceReady=1, SyncIntervalSet=100 -> first grant Grant=1 (status), SyncsSent=1; the next grants are trace.
//  OutTaken held 0 for 20 cycles in OFFER -> OutValid, OutFrame, Grant stable; exactly one TraceNext pulse seen.
//  TraceReady=1 and ReplyValid=1 continuously, MAX_TRACE_RUN=8 -> grant pattern 8 trace, 1 reply, repeating; one ReplyAck per reply grant.
//  SyncIntervalSet=10, OutTaken tied 1, all sources valid -> a status grant occurs at the first IDLE cycle on or after timer==0.
//  SyncIntervalSet=0 -> every grant is status; SyncsSent increments once per grant and wraps 0xFFFF->0.
//  Enable dropped during OFFER -> current frame completes, then no grants and no pulses until Enable=1; rst asserted mid-OFFER -> OutValid=0 immediately.

Source files
------------

// File: rtl/frame_tx_scheduler_if.sv
// Frame handshake bundle between the scheduler, its two frame
// sources (trace buffer, reply generator) and the serialiser.
interface frame_tx_scheduler_if;
  logic [127:0] TraceFrame;
  logic         TraceReady;
  logic         TraceNext;
  logic [127:0] ReplyFrame;
  logic         ReplyValid;
  logic         ReplyAck;
  logic [127:0] OutFrame;
  logic         OutValid;
  logic         OutTaken;

  modport master (
    input  TraceFrame, TraceReady,
    input  ReplyFrame, ReplyValid,
    input  OutTaken,
    output TraceNext, ReplyAck,
    output OutFrame, OutValid
  );

  modport slave (
    output TraceFrame, TraceReady,
    output ReplyFrame, ReplyValid,
    output OutTaken,
    input  TraceNext, ReplyAck,
    input  OutFrame, OutValid
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// Picks the next 128-bit frame for the serialiser: status > starved
// reply > trace > reply, and owns the sync-interval timer.
module frame_tx_scheduler #(
  parameter int SYNC_W        = 23,
  parameter int MAX_TRACE_RUN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enable,
  input  logic [SYNC_W-1:0] SyncIntervalSet,
  input  logic [127:0]      StatusFrame,
  frame_tx_scheduler_if.master bus,
  output logic [1:0]        Grant,
  output logic              SyncDue,
  output logic [15:0]       SyncsSent
);

  localparam int RUN_W = $clog2(MAX_TRACE_RUN + 1);

  typedef enum logic {IDLE, OFFER} state_t;
  typedef enum logic [1:0] {
    G_NONE   = 2'd0,
    G_STATUS = 2'd1,
    G_TRACE  = 2'd2,
    G_REPLY  = 2'd3
  } gnt_t;

  state_t            state;
  state_t            state_nx;
  gnt_t              gnt;
  logic [SYNC_W-1:0] timer;
  logic [RUN_W-1:0]  run;
  logic              run_full;
  logic [127:0]      sel_frame;
  logic [127:0]      out_frame;
  logic              out_valid;
  logic              trace_next;
  logic              reply_ack;

  assign run_full     = (run == RUN_W'(MAX_TRACE_RUN));
  assign SyncDue      = (timer == '0);
  assign bus.OutFrame  = out_frame;
  assign bus.OutValid  = out_valid;
  assign bus.TraceNext = trace_next;
  assign bus.ReplyAck  = reply_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt != G_NONE) state_nx = OFFER;
      OFFER: if (bus.OutTaken)  state_nx = IDLE;
    endcase
  end

  // A reply that has waited out a full trace run beats further trace.
  always_comb begin
    gnt = G_NONE;
    if (state == IDLE && Enable) begin
      if (SyncDue)
        gnt = G_STATUS;
      else if (bus.ReplyValid && run_full)
        gnt = G_REPLY;
      else if (bus.TraceReady)
        gnt = G_TRACE;
      else if (bus.ReplyValid)
        gnt = G_REPLY;
    end
  end

  always_comb begin
    unique case (gnt)
      G_STATUS: sel_frame = StatusFrame;
      G_TRACE:  sel_frame = bus.TraceFrame;
      G_REPLY:  sel_frame = bus.ReplyFrame;
      default:  sel_frame = out_frame;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_frame  <= '0;
      out_valid  <= 1'b0;
      Grant      <= 2'd0;
      trace_next <= 1'b0;
      reply_ack  <= 1'b0;
    end else begin
      trace_next <= (gnt == G_TRACE);
      reply_ack  <= (gnt == G_REPLY);
      if (gnt != G_NONE) begin
        out_frame <= sel_frame;
        out_valid <= 1'b1;
        Grant     <= gnt;
      end else if (state == OFFER && bus.OutTaken) begin
        out_valid <= 1'b0;
        Grant     <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= '0;
    else if (gnt == G_STATUS)
      timer <= SyncIntervalSet;
    else if (timer != '0)
      timer <= timer - SYNC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= '0;
    end else if (gnt == G_TRACE) begin
      if (!bus.ReplyValid) run <= '0;
      else if (!run_full)  run <= run + RUN_W'(1);
    end else if (gnt == G_REPLY) begin
      run <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      SyncsSent <= 16'd0;
    else if (gnt == G_STATUS)
      SyncsSent <= SyncsSent + 16'd1;
  end

endmodule
